irq_ctrl: RTL and testbench
===========================

// Module: irq_ctrl
// PURPOSE
//  Parametrised interrupt/exception controller for the execute stage. Collects NIRQ external
//  lines (per-line edge/level mode) and NEXC synchronous exception pulses (sys, trap, mem),
//  prioritises them, and issues a one-cycle take request with cause and saved PC. Exposes
//  mask/pending/cause/epc on the special-register bus and tracks handler entry/return (irt).
// PARAMETERS
//  RW        16        datapath / SR bus width
//  NIRQ      8         external IRQ lines, 1..RW
//  NEXC      3         synchronous exception sources, 1..8
//  EDGE_MASK 8'hff     bit i=1: line i edge-triggered, 0: level
//  MEM_IDX   2         exception index whose EPC comes from i_mem_pc
//  SR_BASE   16'h0040  SR address of MASK; PENDING +1, CAUSE +2, EPC +3
//  MASK_RST  0         reset value of MASK
// PORTS
//  i_clk          in   1     clock
//  i_rst          in   1     synchronous active-high reset
//  i_irq          in   NIRQ  external lines, synchronous to i_clk
//  i_exc          in   NEXC  exception pulses, valid one cycle
//  i_glob_en      in   1     global IRQ enable (priv ctrl bit 2)
//  i_exec_pc      in   RW    PC of instruction in execute
//  i_mem_pc       in   RW    PC of instruction in memory stage
//  i_irt          in   1     return-from-interrupt executed (one-cycle pulse)
//  i_sr_addr      in   RW    SR bus address
//  i_sr_we        in   1     SR bus write strobe
//  i_sr_data      in   RW    SR bus write data
//  o_sr_data      out  RW    SR read data (0 when address not decoded)
//  o_take         out  1     registered take pulse: flush pipeline, enter handler
//  o_cause        out  8     {is_irq, 7-bit source index}
//  o_epc          out  RW    saved PC
//  o_in_handler   out  1     high from o_take cycle until cycle after i_irt
//  o_double_fault out  1     sticky: exception raised while in handler
// BEHAVIOUR
//  Reset: state IDLE; o_take, o_in_handler, o_double_fault, pending, o_cause, o_epc = 0;
//   MASK = MASK_RST; edge-detect history = 0.
//  Pending: edge line sets bit on 0->1 (history reg), cleared by W1C write to PENDING or when
//   taken; level line bit = raw line each cycle (not clearable). Set beats clear same cycle.
//  FSM IDLE: exc = |i_exc; irq = i_glob_en & |(pending & MASK).
//   If exc or irq -> HANDLER; o_take=1 next cycle, o_cause/o_epc latched on same edge.
//   Priority: any exception over any IRQ; lowest index wins within each group.
//   EPC = i_mem_pc if winner is exception MEM_IDX, else i_exec_pc (decision-cycle values).
//   Taken edge line: its pending bit cleared on take edge.
//  Latency: i_exc at cycle t -> o_take at t+1. Edge IRQ at t -> pending t+1 -> o_take t+2.
//  HANDLER: IRQs ignored (stay pending); any i_exc sets o_double_fault, no new take.
//   i_irt -> IDLE next cycle; a pending IRQ may then be taken one cycle later. i_irt in IDLE ignored.
//  o_take is exactly one cycle wide, never in consecutive cycles.
//  SR bus: writes take effect next cycle; decision in same cycle uses pre-write values.
//   MASK RW (upper bits 0); PENDING RO / W1C edge bits; CAUSE RO ({8'b0,cause});
//   EPC RW (SW write overrides; take in same cycle wins).
//  Reset mid-handler: returns to IDLE, clears pending/double-fault, no o_take.
// TESTING
//  MASK=1, glob_en=1, rise i_irq[0] at t -> o_take t+2, o_cause=8'h80, o_epc=i_exec_pc@t+1.
//  i_exc=3'b101 with i_irq[1] pending -> o_cause=8'h00; i_exc=3'b100 -> o_cause=8'h02, o_epc=i_mem_pc.
//  In HANDLER pulse i_irq[3] edge -> no take; i_irt -> o_take 2 cycles later, o_cause=8'h83.
//  i_exc pulse while o_in_handler=1 -> o_double_fault=1 sticky, o_take stays 0; i_rst clears.
//  Edge pending bit 2 set; write PENDING=16'h0004 same cycle as new edge -> bit stays 1.
//  glob_en=0, level line high -> no take, PENDING reads line; glob_en=1 -> take next cycle.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt/exception controller for the execute stage.
// Collects edge/level external IRQ lines and synchronous exception pulses,
// picks a single winner, and issues a registered one-cycle take request
// together with the cause code and the saved PC. Mask, pending, cause and
// EPC are visible on the special-register bus.
module irq_ctrl #(
  parameter int            RW        = 16,
  parameter int            NIRQ      = 8,
  parameter int            NEXC      = 3,
  parameter logic [RW-1:0] EDGE_MASK = 16'h00ff,
  parameter int            MEM_IDX   = 2,
  parameter logic [RW-1:0] SR_BASE   = 16'h0040,
  parameter logic [RW-1:0] MASK_RST  = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NIRQ-1:0] i_irq,
  input  logic [NEXC-1:0] i_exc,
  input  logic            i_glob_en,
  input  logic [RW-1:0]   i_exec_pc,
  input  logic [RW-1:0]   i_mem_pc,
  input  logic            i_irt,
  input  logic [RW-1:0]   i_sr_addr,
  input  logic            i_sr_we,
  input  logic [RW-1:0]   i_sr_data,
  output logic [RW-1:0]   o_sr_data,
  output logic            o_take,
  output logic [7:0]      o_cause,
  output logic [RW-1:0]   o_epc,
  output logic            o_in_handler,
  output logic            o_double_fault
);

  localparam logic [RW-1:0]   ADDR_MASK  = SR_BASE;
  localparam logic [RW-1:0]   ADDR_PEND  = SR_BASE + RW'(1);
  localparam logic [RW-1:0]   ADDR_CAUSE = SR_BASE + RW'(2);
  localparam logic [RW-1:0]   ADDR_EPC   = SR_BASE + RW'(3);
  localparam logic [NIRQ-1:0] EDGE_LINES = EDGE_MASK[NIRQ-1:0];
  localparam logic [6:0]      MEM_IDX7   = 7'(MEM_IDX);

  typedef enum logic {
    ST_IDLE,
    ST_HANDLER
  } state_t;

  state_t          state_q, state_d;
  logic            take_q, take_d;
  logic            df_q, df_d;
  logic [7:0]      cause_q, cause_d;
  logic [RW-1:0]   epc_q, epc_d;
  logic [NIRQ-1:0] mask_q, mask_d;
  logic [NIRQ-1:0] pending_q, pending_d;
  logic [NIRQ-1:0] hist_q, hist_d;

  logic            wr_mask, wr_pend, wr_epc;
  logic            exc_any, irq_any;
  logic [6:0]      exc_idx, irq_idx;
  logic [NIRQ-1:0] irq_req, irq_sel;
  logic [NIRQ-1:0] take_clr, edge_clr, edge_rise;
  logic [RW-1:0]   sr_rdata;

  // Decode SR bus write strobes for the writable registers
  always_comb begin
    wr_mask = i_sr_we && (i_sr_addr == ADDR_MASK);
    wr_pend = i_sr_we && (i_sr_addr == ADDR_PEND);
    wr_epc  = i_sr_we && (i_sr_addr == ADDR_EPC);
  end

  // Lowest-index exception wins; scanning downward leaves the lowest set bit
  always_comb begin
    exc_any = |i_exc;
    exc_idx = '0;
    for (int j = NEXC - 1; j >= 0; j--) begin
      if (i_exc[j]) begin
        exc_idx = 7'(j);
      end
    end
  end

  // Lowest-index enabled pending IRQ wins, with a one-hot of the winner for clearing
  always_comb begin
    irq_req = i_glob_en ? (pending_q & mask_q) : '0;
    irq_any = |irq_req;
    irq_idx = '0;
    irq_sel = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (irq_req[i]) begin
        irq_idx    = 7'(i);
        irq_sel    = '0;
        irq_sel[i] = 1'b1;
      end
    end
  end

  // Control FSM: decide on a take in IDLE, watch for faults and return in HANDLER
  always_comb begin
    state_d  = state_q;
    take_d   = 1'b0;
    df_d     = df_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    mask_d   = mask_q;
    take_clr = '0;

    if (wr_mask) begin
      mask_d = i_sr_data[NIRQ-1:0];
    end
    if (wr_epc) begin
      epc_d = i_sr_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (exc_any) begin
          state_d = ST_HANDLER;
          take_d  = 1'b1;
          cause_d = {1'b0, exc_idx};
          epc_d   = (exc_idx == MEM_IDX7) ? i_mem_pc : i_exec_pc;
        end else if (irq_any) begin
          state_d  = ST_HANDLER;
          take_d   = 1'b1;
          cause_d  = {1'b1, irq_idx};
          epc_d    = i_exec_pc;
          take_clr = irq_sel;
        end
      end
      ST_HANDLER: begin
        if (exc_any) begin
          df_d = 1'b1;
        end
        if (i_irt) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pending bits: edge lines latch rising edges until cleared, level lines follow the pin
  always_comb begin
    hist_d    = i_irq;
    edge_rise = i_irq & ~hist_q & EDGE_LINES;
    edge_clr  = (wr_pend ? i_sr_data[NIRQ-1:0] : '0) | take_clr;
    pending_d = (EDGE_LINES & (edge_rise | (pending_q & ~edge_clr)))
              | (~EDGE_LINES & i_irq);
  end

  // State and register update with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      take_q    <= 1'b0;
      df_q      <= 1'b0;
      cause_q   <= '0;
      epc_q     <= '0;
      mask_q    <= MASK_RST[NIRQ-1:0];
      pending_q <= '0;
      hist_q    <= '0;
    end else begin
      state_q   <= state_d;
      take_q    <= take_d;
      df_q      <= df_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      mask_q    <= mask_d;
      pending_q <= pending_d;
      hist_q    <= hist_d;
    end
  end

  // SR read mux, zero for addresses outside the register window
  always_comb begin
    sr_rdata = '0;
    if (i_sr_addr == ADDR_MASK) begin
      sr_rdata = RW'(mask_q);
    end else if (i_sr_addr == ADDR_PEND) begin
      sr_rdata = RW'(pending_q);
    end else if (i_sr_addr == ADDR_CAUSE) begin
      sr_rdata = RW'(cause_q);
    end else if (i_sr_addr == ADDR_EPC) begin
      sr_rdata = epc_q;
    end
  end

  assign o_sr_data      = sr_rdata;
  assign o_take         = take_q;
  assign o_cause        = cause_q;
  assign o_epc          = epc_q;
  assign o_in_handler   = (state_q == ST_HANDLER);
  assign o_double_fault = df_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios plus a randomized run against a behavioural
// model of the interrupt controller. Line 7 is configured as a level line.
module tb_irq_ctrl;

  localparam logic [15:0] EDGE_MASK  = 16'h007f;
  localparam logic [7:0]  EDGE_LINES = 8'h7f;
  localparam logic [15:0] A_MASK  = 16'h0040;
  localparam logic [15:0] A_PEND  = 16'h0041;
  localparam logic [15:0] A_CAUSE = 16'h0042;
  localparam logic [15:0] A_EPC   = 16'h0043;

  logic        clk, rst;
  logic [7:0]  irq;
  logic [2:0]  exc;
  logic        glob_en, irt, sr_we;
  logic [15:0] exec_pc, mem_pc, sr_addr, sr_data;
  logic [15:0] o_sr_data, o_epc;
  logic        o_take, o_in_handler, o_double_fault;
  logic [7:0]  o_cause;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_busy, m_take, m_df;
  bit [7:0]    m_pend, m_mask, m_hist, m_cause;
  bit [15:0]   m_epc;

  irq_ctrl #(
    .RW(16), .NIRQ(8), .NEXC(3), .EDGE_MASK(EDGE_MASK),
    .MEM_IDX(2), .SR_BASE(16'h0040), .MASK_RST(16'h0000)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_irq(irq), .i_exc(exc), .i_glob_en(glob_en),
    .i_exec_pc(exec_pc), .i_mem_pc(mem_pc), .i_irt(irt),
    .i_sr_addr(sr_addr), .i_sr_we(sr_we), .i_sr_data(sr_data),
    .o_sr_data(o_sr_data), .o_take(o_take), .o_cause(o_cause), .o_epc(o_epc),
    .o_in_handler(o_in_handler), .o_double_fault(o_double_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected SR read value from the model's registers
  function automatic logic [15:0] model_read(logic [15:0] a);
    if (a == A_MASK)  return {8'h00, m_mask};
    if (a == A_PEND)  return {8'h00, m_pend};
    if (a == A_CAUSE) return {8'h00, m_cause};
    if (a == A_EPC)   return m_epc;
    return 16'h0000;
  endfunction

  // Advance one clock: evaluate the model on the current inputs, then clock the DUT
  task automatic step();
    int        ew, iw;
    bit [7:0]  n_pend, n_mask, n_cause, n_hist;
    bit [15:0] n_epc;
    bit        n_busy, n_take, n_df, rise, clr;
    ew = -1;
    iw = -1;
    if (rst) begin
      n_busy = 0; n_take = 0; n_df = 0; n_pend = 0; n_mask = 0;
      n_cause = 0; n_epc = 0; n_hist = 0;
    end else begin
      n_busy = m_busy; n_take = 0; n_df = m_df; n_cause = m_cause;
      n_epc = m_epc; n_mask = m_mask; n_hist = irq;
      for (int j = 0; j < 3; j++) if (exc[j] && ew < 0) ew = j;
      if (sr_we && sr_addr == A_EPC) n_epc = sr_data;
      if (sr_we && sr_addr == A_MASK) n_mask = sr_data[7:0];
      if (!m_busy) begin
        if (ew >= 0) begin
          n_take = 1; n_busy = 1; n_cause = 8'(ew);
          n_epc = (ew == 2) ? mem_pc : exec_pc;
        end else if (glob_en) begin
          for (int i = 0; i < 8; i++) if (m_pend[i] && m_mask[i] && iw < 0) iw = i;
          if (iw >= 0) begin
            n_take = 1; n_busy = 1; n_cause = 8'h80 + 8'(iw); n_epc = exec_pc;
          end
        end
      end else begin
        if (ew >= 0) n_df = 1;
        if (irt) n_busy = 0;
      end
      for (int i = 0; i < 8; i++) begin
        if (EDGE_LINES[i]) begin
          rise = irq[i] && !m_hist[i];
          clr  = (sr_we && sr_addr == A_PEND && sr_data[i]) || (iw == i);
          n_pend[i] = rise || (m_pend[i] && !clr);
        end else begin
          n_pend[i] = irq[i];
        end
      end
    end
    @(posedge clk);
    #1;
    m_busy = n_busy; m_take = n_take; m_df = n_df; m_pend = n_pend;
    m_mask = n_mask; m_cause = n_cause; m_epc = n_epc; m_hist = n_hist;
  endtask

  // Reset values of every output and readable register
  task automatic test_reset();
    rst = 1; step(); step();
    checks++; if (o_take !== 1'b0) begin errors++; $display("[TB] FAIL reset_take got=%0h exp=0", o_take); end
    checks++; if (o_in_handler !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_handler got=%0h exp=0", o_in_handler); end
    checks++; if (o_double_fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_df got=%0h exp=0", o_double_fault); end
    checks++; if (o_cause !== 8'h00) begin errors++; $display("[TB] FAIL reset_cause got=%0h exp=0", o_cause); end
    checks++; if (o_epc !== 16'h0000) begin errors++; $display("[TB] FAIL reset_epc got=%0h exp=0", o_epc); end
    sr_addr = A_MASK; #1;
    checks++; if (o_sr_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_mask got=%0h exp=0", o_sr_data); end
    rst = 0;
  endtask

  // Edge IRQ on line 0: pending after one cycle, take after two
  task automatic test_irq_edge();
    glob_en = 1; sr_we = 1; sr_addr = A_MASK; sr_data = 16'h0001; step();
    sr_we = 0; sr_addr = A_PEND;
    irq[0] = 1; exec_pc = 16'h1000; step();
    checks++; if (o_take !== 1'b0) begin errors++; $display("[TB] FAIL edge_early_take got=%0h exp=0", o_take); end
    checks++; if (o_sr_data !== 16'h0001) begin errors++; $display("[TB] FAIL edge_pending got=%0h exp=1", o_sr_data); end
    exec_pc = 16'h1111; step();
    checks++; if (o_take !== 1'b1) begin errors++; $display("[TB] FAIL edge_take got=%0h exp=1", o_take); end
    checks++; if (o_cause !== 8'h80) begin errors++; $display("[TB] FAIL edge_cause got=%0h exp=80", o_cause); end
    checks++; if (o_epc !== 16'h1111) begin errors++; $display("[TB] FAIL edge_epc got=%0h exp=1111", o_epc); end
    checks++; if (o_in_handler !== 1'b1) begin errors++; $display("[TB] FAIL edge_in_handler got=%0h exp=1", o_in_handler); end
    checks++; if (o_sr_data !== 16'h0000) begin errors++; $display("[TB] FAIL edge_pending_cleared got=%0h exp=0", o_sr_data); end
    step();
    checks++; if (o_take !== 1'b0) begin errors++; $display("[TB] FAIL edge_take_width got=%0h exp=0", o_take); end
    irt = 1; step(); irt = 0;
    checks++; if (o_in_handler !== 1'b0) begin errors++; $display("[TB] FAIL edge_irt_exit got=%0h exp=0", o_in_handler); end
    irq[0] = 0; step();
    checks++; if (o_take !== 1'b0) begin errors++; $display("[TB] FAIL edge_no_retake got=%0h exp=0", o_take); end
  endtask

  // Exceptions beat pending IRQs; exception 2 saves the memory-stage PC
  task automatic test_exc_priority();
    glob_en = 0; sr_we = 1; sr_addr = A_MASK; sr_data = 16'h0002; irq[1] = 1; step();
    sr_we = 0; irq[1] = 0; sr_addr = A_PEND; step();
    checks++; if (o_sr_data !== 16'h0002) begin errors++; $display("[TB] FAIL prio_pending got=%0h exp=2", o_sr_data); end
    glob_en = 1; exc = 3'b101; exec_pc = 16'h3333; mem_pc = 16'h2222; step(); exc = 0;
    checks++; if (o_take !== 1'b1) begin errors++; $display("[TB] FAIL prio_take got=%0h exp=1", o_take); end
    checks++; if (o_cause !== 8'h00) begin errors++; $display("[TB] FAIL prio_cause got=%0h exp=00", o_cause); end
    checks++; if (o_epc !== 16'h3333) begin errors++; $display("[TB] FAIL prio_epc got=%0h exp=3333", o_epc); end
    glob_en = 0; irt = 1; step(); irt = 0;
    exc = 3'b100; exec_pc = 16'h4444; mem_pc = 16'h5555; step(); exc = 0;
    checks++; if (o_cause !== 8'h02) begin errors++; $display("[TB] FAIL mem_cause got=%0h exp=02", o_cause); end
    checks++; if (o_epc !== 16'h5555) begin errors++; $display("[TB] FAIL mem_epc got=%0h exp=5555", o_epc); end
    irt = 1; step(); irt = 0; glob_en = 1; step();
    checks++; if (o_take !== 1'b1) begin errors++; $display("[TB] FAIL prio_late_irq_take got=%0h exp=1", o_take); end
    checks++; if (o_cause !== 8'h81) begin errors++; $display("[TB] FAIL prio_late_irq_cause got=%0h exp=81", o_cause); end
    irt = 1; step(); irt = 0;
  endtask

  // IRQ arriving inside a handler waits until after the return
  task automatic test_handler_irq();
    sr_we = 1; sr_addr = A_MASK; sr_data = 16'h0008; step(); sr_we = 0; sr_addr = A_PEND;
    exc = 3'b001; step(); exc = 0;
    checks++; if (o_take !== 1'b1) begin errors++; $display("[TB] FAIL hnd_enter got=%0h exp=1", o_take); end
    irq[3] = 1; step(); irq[3] = 0; step();
    checks++; if (o_take !== 1'b0) begin errors++; $display("[TB] FAIL hnd_irq_ignored got=%0h exp=0", o_take); end
    checks++; if (o_sr_data !== 16'h0008) begin errors++; $display("[TB] FAIL hnd_irq_pending got=%0h exp=8", o_sr_data); end
    irt = 1; step(); irt = 0;
    checks++; if (o_take !== 1'b0) begin errors++; $display("[TB] FAIL hnd_irt_gap got=%0h exp=0", o_take); end
    step();
    checks++; if (o_take !== 1'b1) begin errors++; $display("[TB] FAIL hnd_after_irt_take got=%0h exp=1", o_take); end
    checks++; if (o_cause !== 8'h83) begin errors++; $display("[TB] FAIL hnd_after_irt_cause got=%0h exp=83", o_cause); end
    irt = 1; step(); irt = 0;
  endtask

  // Set from a new edge beats a W1C clear in the same cycle
  task automatic test_w1c_race();
    glob_en = 0; sr_addr = A_PEND;
    irq[2] = 1; step(); irq[2] = 0; step();
    checks++; if (o_sr_data !== 16'h0004) begin errors++; $display("[TB] FAIL w1c_set got=%0h exp=4", o_sr_data); end
    irq[2] = 1; sr_we = 1; sr_data = 16'h0004; step(); sr_we = 0; irq[2] = 0;
    checks++; if (o_sr_data !== 16'h0004) begin errors++; $display("[TB] FAIL w1c_race got=%0h exp=4", o_sr_data); end
    sr_we = 1; sr_data = 16'h0004; step(); sr_we = 0;
    checks++; if (o_sr_data !== 16'h0000) begin errors++; $display("[TB] FAIL w1c_clear got=%0h exp=0", o_sr_data); end
  endtask

  // Level line 7: follows the pin, held off by glob_en, not cleared by the take
  task automatic test_level();
    glob_en = 0; sr_we = 1; sr_addr = A_MASK; sr_data = 16'h0080; irq[7] = 1; step();
    sr_we = 0; sr_addr = A_PEND; step();
    checks++; if (o_sr_data !== 16'h0080) begin errors++; $display("[TB] FAIL lvl_pending got=%0h exp=80", o_sr_data); end
    checks++; if (o_take !== 1'b0) begin errors++; $display("[TB] FAIL lvl_masked_take got=%0h exp=0", o_take); end
    glob_en = 1; step();
    checks++; if (o_take !== 1'b1) begin errors++; $display("[TB] FAIL lvl_take got=%0h exp=1", o_take); end
    checks++; if (o_cause !== 8'h87) begin errors++; $display("[TB] FAIL lvl_cause got=%0h exp=87", o_cause); end
    checks++; if (o_sr_data !== 16'h0080) begin errors++; $display("[TB] FAIL lvl_not_cleared got=%0h exp=80", o_sr_data); end
    irq[7] = 0; glob_en = 0; irt = 1; step(); irt = 0; step();
    checks++; if (o_sr_data !== 16'h0000) begin errors++; $display("[TB] FAIL lvl_drop got=%0h exp=0", o_sr_data); end
  endtask

  // Exception inside a handler: sticky double fault, no new take, cleared by reset
  task automatic test_double_fault();
    glob_en = 0; exc = 3'b010; step(); exc = 0;
    checks++; if (o_cause !== 8'h01) begin errors++; $display("[TB] FAIL df_enter_cause got=%0h exp=01", o_cause); end
    exc = 3'b100; step(); exc = 0;
    checks++; if (o_double_fault !== 1'b1) begin errors++; $display("[TB] FAIL df_set got=%0h exp=1", o_double_fault); end
    checks++; if (o_take !== 1'b0) begin errors++; $display("[TB] FAIL df_no_take got=%0h exp=0", o_take); end
    step(); step();
    checks++; if (o_double_fault !== 1'b1) begin errors++; $display("[TB] FAIL df_sticky got=%0h exp=1", o_double_fault); end
    rst = 1; step(); rst = 0;
    checks++; if (o_double_fault !== 1'b0) begin errors++; $display("[TB] FAIL df_reset got=%0h exp=0", o_double_fault); end
    checks++; if (o_in_handler !== 1'b0) begin errors++; $display("[TB] FAIL df_reset_handler got=%0h exp=0", o_in_handler); end
    step();
    checks++; if (o_take !== 1'b0) begin errors++; $display("[TB] FAIL df_reset_take got=%0h exp=0", o_take); end
  endtask

  // SR bus: EPC write/readback, take wins over a same-cycle EPC write, MASK width
  task automatic test_epc_sr();
    glob_en = 0; sr_we = 1; sr_addr = A_EPC; sr_data = 16'hBEEF; step(); sr_we = 0;
    checks++; if (o_sr_data !== 16'hBEEF) begin errors++; $display("[TB] FAIL epc_readback got=%0h exp=beef", o_sr_data); end
    sr_we = 1; sr_data = 16'h1234; exc = 3'b010; exec_pc = 16'h5A5A; step(); sr_we = 0; exc = 0;
    checks++; if (o_epc !== 16'h5A5A) begin errors++; $display("[TB] FAIL epc_take_wins got=%0h exp=5a5a", o_epc); end
    sr_addr = A_CAUSE; #1;
    checks++; if (o_sr_data !== 16'h0001) begin errors++; $display("[TB] FAIL cause_read got=%0h exp=1", o_sr_data); end
    irt = 1; sr_we = 1; sr_addr = A_MASK; sr_data = 16'hFFA5; step(); sr_we = 0; irt = 0;
    checks++; if (o_sr_data !== 16'h00A5) begin errors++; $display("[TB] FAIL mask_width got=%0h exp=a5", o_sr_data); end
    sr_addr = 16'h0044; #1;
    checks++; if (o_sr_data !== 16'h0000) begin errors++; $display("[TB] FAIL unmapped_read got=%0h exp=0", o_sr_data); end
  endtask

  // Randomized traffic compared cycle by cycle against the model
  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 2) == 0) irq = 8'($urandom);
      exc     = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b000;
      irt     = ($urandom_range(0, 5) == 0);
      glob_en = ($urandom_range(0, 7) != 0);
      sr_we   = ($urandom_range(0, 3) == 0);
      sr_addr = 16'h003F + 16'($urandom_range(0, 5));
      sr_data = 16'($urandom);
      exec_pc = 16'($urandom);
      mem_pc  = 16'($urandom);
      step();
      checks++; if (o_take !== m_take) begin errors++; $display("[TB] FAIL rnd_take n=%0d got=%0h exp=%0h", n, o_take, m_take); end
      checks++; if (o_cause !== m_cause) begin errors++; $display("[TB] FAIL rnd_cause n=%0d got=%0h exp=%0h", n, o_cause, m_cause); end
      checks++; if (o_epc !== m_epc) begin errors++; $display("[TB] FAIL rnd_epc n=%0d got=%0h exp=%0h", n, o_epc, m_epc); end
      checks++; if (o_in_handler !== m_busy) begin errors++; $display("[TB] FAIL rnd_in_handler n=%0d got=%0h exp=%0h", n, o_in_handler, m_busy); end
      checks++; if (o_double_fault !== m_df) begin errors++; $display("[TB] FAIL rnd_df n=%0d got=%0h exp=%0h", n, o_double_fault, m_df); end
      checks++; if (o_sr_data !== model_read(sr_addr)) begin errors++; $display("[TB] FAIL rnd_sr_read n=%0d addr=%0h got=%0h exp=%0h", n, sr_addr, o_sr_data, model_read(sr_addr)); end
    end
  endtask

  // Scenario sequence
  initial begin
    rst = 1; irq = 0; exc = 0; glob_en = 0; irt = 0; sr_we = 0;
    exec_pc = 0; mem_pc = 0; sr_addr = 0; sr_data = 0;
    m_busy = 0; m_take = 0; m_df = 0; m_pend = 0; m_mask = 0;
    m_hist = 0; m_cause = 0; m_epc = 0;
    $display("[TB] starting irq_ctrl bench");
    test_reset();
    test_irq_edge();
    test_exc_priority();
    test_handler_irq();
    test_w1c_race();
    test_level();
    test_double_fault();
    test_epc_sr();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
